seq_add_flags: RTL and testbench
================================

Name: seq_add_flags

Overview:
- Parametrised, chunk-serial successor to the combinational ADD flag block.
- Adds CHUNK bits per clock over WIDTH/CHUNK cycles, using a start/busy/done handshake.
- Supports add, add-with-carry, subtract, subtract-with-carry and reverse-subtract modes.
- Holds an internal NZCV flag register, updated only when S is set, for use in multi-word arithmetic in the ALU datapath.

Parameters:
- WIDTH, 32: operand and result width in bits.
- CHUNK, 8: bits added per cycle. Must divide WIDTH. N = WIDTH/CHUNK.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  request a new operation; sampled only when Busy=0.
- Op  input  3  000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 RSB; 101-111 reserved, executed as ADD.
- In1  input  WIDTH  operand A, signed two's complement.
- In2  input  WIDTH  operand B, signed two's complement.
- S  input  1  1 = update the flag register on completion.
- Result  output  WIDTH  last completed result; registered.
- Flag  output  4  flag register, ordered {N,Z,C,V}.
- Busy  output  1  operation in progress.
- Done  output  1  single-cycle completion pulse.

Behaviour:
- Reset (synchronous, active-high):
  - Result=0, Flag=0000, Busy=0, Done=0, state IDLE, chunk counter=0.
  - Reset mid-operation aborts: no Result or Flag write, no Done pulse.
- States:
  - IDLE: Busy=0, waiting for Start.
  - RUN: Busy=1, chunk counter 0..N-1.
  - Done is a registered pulse emitted on the RUN->IDLE transition; there is no separate DONE state.
- Start accept (IDLE, Start=1 at edge E0), the block latches:
  - A' and B': ADD/ADC: A'=In1, B'=In2. SUB/SBC: A'=In1, B'=~In2. RSB: A'=In2, B'=~In1.
  - Carry-in: ADD 0; ADC Flag.C; SUB 1; SBC Flag.C; RSB 1. The Flag.C used is the value at E0.
  - S is also latched. In1, In2, Op and S may change freely after E0.
- RUN:
  - At edge E(i+1), i=0..N-1, add chunk i (bits i*CHUNK .. i*CHUNK+CHUNK-1) of A', B' and the running carry.
  - Store the sum chunk into an internal accumulator and keep the carry-out for the next chunk.
  - Track the carry into the MSB during the final chunk.
- Completion at edge EN:
  - Result = full sum, mod 2^WIDTH. Result is always written, regardless of S.
  - If latched S=1, Flag is written as:
    - N = Result[WIDTH-1]
    - Z = (Result==0)
    - C = final carry-out. For SUB/SBC/RSB, C=1 means no borrow.
    - V = carry into MSB XOR carry-out.
  - If S=0, Flag holds its value.
  - Done=1 for exactly the one cycle after EN; Busy=0 in that same cycle; state returns to IDLE.
- Latency: Done is high N cycles after the Start edge. Throughput is one operation per N cycles.
- Start while Busy=1 is ignored, with no queueing.
- Start in the Done cycle is accepted (back-to-back). An ADC/SBC issued this way sees the flags just written.
- Result and Flag are stable between completions; the intermediate accumulator is never visible on Result.

Test Plan (WIDTH=32, CHUNK=8, N=4):
1. Signed overflow: ADD, In1=0x60000000, In2=0x20000001, S=1 -> after exactly 4 cycles Done pulses 1 cycle, Result=0x80000001, Flag=1001.
2. Carry out: ADD, 0xFFFFFFFF + 0xFFFFFFFF, S=1 -> Result=0xFFFFFFFE, Flag=1010.
3. Subtract and flag hold:
   - SUB 4-4, S=1 -> Result=0, Flag=0110.
   - Then SUB 1-3, S=1 -> Result=0xFFFFFFFE, Flag=1000.
   - Then ADD 10+10, S=0 -> Result=20, Flag stays 1000.
4. Carry chaining, back-to-back:
   - ADD 0xFFFFFFFF + 1, S=1 -> Result=0, Flag=0110.
   - ADC 0+0 issued in the Done cycle -> Result=1, Flag=0000.
   - SBC 5-2 with C=0 -> Result=2.
5. RSB: In1=3, In2=1, S=1 -> Result=0xFFFFFFFE, Flag=1000. Reserved Op=111 with -6+8 -> Result=2, Flag=0010.
6. Handshake robustness:
   - Start pulsed while Busy=1 -> ignored; the original result is unchanged.
   - reset asserted in RUN cycle 2 -> next cycle Busy=0, Done=0, Result=0, Flag=0000, and no Done pulse follows.

Source files
------------

// File: rtl/seq_add_flags.sv
// Chunk-serial adder/subtractor with a start/busy/done handshake and an NZCV flag register.
// Adds CHUNK bits per clock; ADC/SBC chain through the stored C flag for multi-word arithmetic.
module seq_add_flags #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             S,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       Flag,
  output logic             Busy,
  output logic             Done
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_result;
  logic             r_carry, r_s, r_done;
  logic [3:0]       r_flag;

  logic             w_accept, w_last;
  logic [WIDTH-1:0] w_a_init, w_b_init;
  logic             w_cin_init;
  logic [CHUNK-1:0] w_a_chunk, w_b_chunk;
  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_full;
  logic             w_cin_msb;
  logic [3:0]       w_flag_new;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      IDLE: if (Start) begin
        w_accept = 1'b1;
        w_next   = RUN;
      end
      RUN: if (r_cnt == CNT_W'(N - 1)) begin
        w_last = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Subtraction forms are A + ~B + 1; SBC/ADC take carry-in from the stored C flag.
  always_comb begin
    w_a_init   = In1;
    w_b_init   = In2;
    w_cin_init = 1'b0;
    case (Op)
      3'b001: w_cin_init = r_flag[1];
      3'b010: begin w_b_init = ~In2; w_cin_init = 1'b1;      end
      3'b011: begin w_b_init = ~In2; w_cin_init = r_flag[1]; end
      3'b100: begin w_a_init = In2; w_b_init = ~In1; w_cin_init = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    w_a_chunk = r_a[r_cnt*CHUNK +: CHUNK];
    w_b_chunk = r_b[r_cnt*CHUNK +: CHUNK];
    w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    w_full    = r_acc;
    w_full[r_cnt*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
    w_cin_msb  = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_sum[CHUNK-1];
    w_flag_new = {w_full[WIDTH-1], (w_full == '0), w_sum[CHUNK], w_cin_msb ^ w_sum[CHUNK]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_result <= '0;
      r_flag   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        if (w_last) begin
          r_result <= w_full;
          if (r_s) r_flag <= w_flag_new;
        end
      end
    end
  end

  // NOTE: operand/accumulator registers carry no reset; they are always loaded on accept before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a     <= w_a_init;
      r_b     <= w_b_init;
      r_carry <= w_cin_init;
      r_s     <= S;
      r_acc   <= '0;
    end else if (r_state == RUN) begin
      r_acc   <= w_full;
      r_carry <= w_sum[CHUNK];
    end
  end

  assign Result = r_result;
  assign Flag   = r_flag;
  assign Busy   = (r_state == RUN);
  assign Done   = r_done;

endmodule

// File: tb/tb_seq_add_flags.sv
// Self-checking bench for seq_add_flags: directed scenarios plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_seq_add_flags;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic             clk = 1'b0;
  logic             reset;
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] In1, In2;
  logic             S;
  logic [WIDTH-1:0] Result;
  logic [3:0]       Flag;
  logic             Busy, Done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] m_result;
  logic [3:0]       m_flag;

  seq_add_flags #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op), .In1(In1), .In2(In2), .S(S),
    .Result(Result), .Flag(Flag), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: signed and unsigned arithmetic on the operand forms each op implies.
  function automatic void ref_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                 input logic cflag, output logic [31:0] res, output logic [3:0] fl);
    logic [31:0] a, b;
    logic        cin;
    logic [32:0] full;
    longint      sfull;
    a = x; b = y; cin = 1'b0;
    case (op)
      3'd1: cin = cflag;
      3'd2: begin b = ~y; cin = 1'b1; end
      3'd3: begin b = ~y; cin = cflag; end
      3'd4: begin a = y; b = ~x; cin = 1'b1; end
      default: ;
    endcase
    full  = {1'b0, a} + {1'b0, b} + 33'(cin);
    sfull = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    res   = full[31:0];
    fl    = {res[31], res == 32'd0, full[32], (sfull > SMAX) || (sfull < SMIN)};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Called at #1 after a clock edge with the DUT idle (or in its Done cycle).
  // poke=1 pulses Start mid-run with junk operands, which must be ignored.
  task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic s, input logic poke);
    logic [31:0] exp_res;
    logic [3:0]  exp_fl;
    int          cycles;
    ref_op(op, x, y, m_flag[1], exp_res, exp_fl);
    Start = 1'b1; Op = op; In1 = x; In2 = y; S = s;
    @(posedge clk); #1;
    Start = 1'b0; Op = 3'($urandom); In1 = $urandom; In2 = $urandom; S = 1'($urandom);
    cycles = 0;
    while (Done !== 1'b1 && cycles < 4 * N) begin
      check("busy_run", 32'(Busy), 32'd1);
      check("hold_result", Result, m_result);
      check("hold_flag", 32'(Flag), 32'(m_flag));
      Start = poke && (cycles == 1);
      @(posedge clk); #1;
      cycles++;
    end
    Start = 1'b0;
    check("latency", cycles, N);
    check("busy_done", 32'(Busy), 32'd0);
    m_result = exp_res;
    if (s) m_flag = exp_fl;
    check("result", Result, m_result);
    check("flag", 32'(Flag), 32'(m_flag));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      check("done_low", 32'(Done), 32'd0);
      check("busy_low", 32'(Busy), 32'd0);
      check("idle_result", Result, m_result);
      check("idle_flag", 32'(Flag), 32'(m_flag));
    end
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; Op = 3'd0; In1 = '0; In2 = '0; S = 1'b0;
    m_result = '0; m_flag = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", Result, 32'd0);
    check("rst_flag", 32'(Flag), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    reset = 1'b0;
    idle(1);

    // Signed overflow
    do_op(3'd0, 32'h6000_0000, 32'h2000_0001, 1'b1, 1'b0);
    check("t1_res", Result, 32'h8000_0001);
    check("t1_flag", 32'(Flag), 32'b1001);
    idle(1);

    // Carry out
    do_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("t2_res", Result, 32'hFFFF_FFFE);
    check("t2_flag", 32'(Flag), 32'b1010);
    idle(2);

    // Subtract and flag hold
    do_op(3'd2, 32'd4, 32'd4, 1'b1, 1'b0);
    check("t3a_res", Result, 32'd0);
    check("t3a_flag", 32'(Flag), 32'b0110);
    do_op(3'd2, 32'd1, 32'd3, 1'b1, 1'b0);
    check("t3b_res", Result, 32'hFFFF_FFFE);
    check("t3b_flag", 32'(Flag), 32'b1000);
    do_op(3'd0, 32'd10, 32'd10, 1'b0, 1'b0);
    check("t3c_res", Result, 32'd20);
    check("t3c_flag", 32'(Flag), 32'b1000);
    idle(1);

    // Carry chaining, back-to-back
    do_op(3'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
    check("t4a_res", Result, 32'd0);
    check("t4a_flag", 32'(Flag), 32'b0110);
    do_op(3'd1, 32'd0, 32'd0, 1'b1, 1'b0);
    check("t4b_res", Result, 32'd1);
    check("t4b_flag", 32'(Flag), 32'b0000);
    do_op(3'd3, 32'd5, 32'd2, 1'b1, 1'b0);
    check("t4c_res", Result, 32'd2);
    check("t4c_flag", 32'(Flag), 32'b0010);
    idle(1);

    // Reverse subtract and reserved op
    do_op(3'd4, 32'd3, 32'd1, 1'b1, 1'b0);
    check("t5a_res", Result, 32'hFFFF_FFFE);
    check("t5a_flag", 32'(Flag), 32'b1000);
    do_op(3'd7, 32'hFFFF_FFFA, 32'd8, 1'b1, 1'b0);
    check("t5b_res", Result, 32'd2);
    check("t5b_flag", 32'(Flag), 32'b0010);
    idle(1);

    // Start while busy is ignored
    do_op(3'd0, 32'd100, 32'd23, 1'b1, 1'b1);
    check("t6a_res", Result, 32'd123);
    idle(N + 1);

    // Reset in RUN cycle 2 aborts without a Done pulse
    Start = 1'b1; Op = 3'd0; In1 = 32'h1234_5678; In2 = 32'h1111_1111; S = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6b_busy", 32'(Busy), 32'd0);
    check("t6b_done", 32'(Done), 32'd0);
    check("t6b_res", Result, 32'd0);
    check("t6b_flag", 32'(Flag), 32'd0);
    reset = 1'b0;
    m_result = '0; m_flag = '0;
    idle(N + 2);

    // Randomized ops, mixing back-to-back issue and idle gaps
    for (int i = 0; i < 200; i++) begin
      do_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
